accel_spi_slave: RTL

ACCEL_SPI_SLAVE -- requirements
Module: accel_spi_slave

---
 rtl/accel_spi_slave.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/accel_spi_slave.sv
// accel_spi_slave: SPI mode-0 slave that exposes a small accelerometer-style
// register file. It holds ID bytes, free-running X/Y/Z samples that change only
// in measure mode, a POWER_CTL register and general read/write storage.
module accel_spi_slave #(
  parameter int ADDR_W        = 6,
  parameter int UPDATE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic CS,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WRITE,
    S_READ,
    S_IGNORE
  } state_t;

  localparam int                DEPTH        = 1 << ADDR_W;
  localparam int                PW           = $clog2(UPDATE_CYCLES + 1);
  localparam logic [ADDR_W-1:0] L_PWR_ADDR   = ADDR_W'(8'h2D);
  localparam logic [PW-1:0]     L_PRESC_LAST = PW'(UPDATE_CYCLES - 1);

  state_t            r_state;
  state_t            w_nextState;

  logic [1:0]        r_csSync;
  logic [1:0]        r_sclkSync;
  logic [1:0]        r_mosiSync;
  logic              r_csPrev;
  logic              r_sclkPrev;

  logic [2:0]        r_bitCnt;
  logic [6:0]        r_shiftIn;
  logic [6:0]        r_shiftOut;
  logic              r_miso;
  logic              r_isRead;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_mem [DEPTH];

  logic [PW-1:0]     r_presc;
  logic [15:0]       r_x, r_y, r_z;
  logic [15:0]       r_snapX, r_snapY, r_snapZ;

  logic              w_csHigh;
  logic              w_csFall;
  logic              w_sclkRise;
  logic              w_sclkFall;
  logic              w_mosi;
  logic              w_byteDone;
  logic [7:0]        w_byte;
  logic [7:0]        w_ptr8;
  logic              w_writable;
  logic [7:0]        w_rdData;
  logic              w_measure;

  logic              w_cmdDone;
  logic              w_ptrLoad;
  logic              w_ptrInc;
  logic              w_wrEn;
  logic              w_outLoad;
  logic              w_outShift;

  // Bring the asynchronous SPI pins into the clk domain and keep one extra
  // stage of history so edges can be found on the synchronized levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_csSync   <= 2'b11;
      r_sclkSync <= 2'b00;
      r_mosiSync <= 2'b00;
      r_csPrev   <= 1'b1;
      r_sclkPrev <= 1'b0;
    end else begin
      r_csSync   <= {r_csSync[0], CS};
      r_sclkSync <= {r_sclkSync[0], SCLK};
      r_mosiSync <= {r_mosiSync[0], MOSI};
      r_csPrev   <= r_csSync[1];
      r_sclkPrev <= r_sclkSync[1];
    end
  end

  assign w_csHigh   = r_csSync[1];
  assign w_csFall   = r_csPrev & ~r_csSync[1];
  assign w_sclkRise = ~r_sclkPrev & r_sclkSync[1];
  assign w_sclkFall = r_sclkPrev & ~r_sclkSync[1];
  assign w_mosi     = r_mosiSync[1];
  assign w_byte     = {r_shiftIn, w_mosi};
  assign w_byteDone = w_sclkRise && !w_csHigh && (r_bitCnt == 3'd7);
  assign w_ptr8     = 8'(r_ptr);
  assign w_measure  = (r_mem[L_PWR_ADDR][1:0] == 2'b10);

  // ID bytes and sample bytes are read-only; everything else accepts writes.
  assign w_writable = !((w_ptr8 <= 8'h02) || ((w_ptr8 >= 8'h0E) && (w_ptr8 <= 8'h13)));

  // Register map read mux; sample bytes come from the snapshot taken at CS fall.
  always_comb begin
    w_rdData = r_mem[r_ptr];
    case (w_ptr8)
      8'h00:   w_rdData = 8'hAD;
      8'h01:   w_rdData = 8'h1D;
      8'h02:   w_rdData = 8'hF2;
      8'h0E:   w_rdData = r_snapX[7:0];
      8'h0F:   w_rdData = r_snapX[15:8];
      8'h10:   w_rdData = r_snapY[7:0];
      8'h11:   w_rdData = r_snapY[15:8];
      8'h12:   w_rdData = r_snapZ[7:0];
      8'h13:   w_rdData = r_snapZ[15:8];
      default: ;
    endcase
  end

  // Transaction state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; CS high wins over any SCLK activity in the same cycle.
  always_comb begin
    w_nextState = r_state;
    if (w_csHigh) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_csFall) w_nextState = S_CMD;
        S_CMD: begin
          if (w_byteDone) begin
            if ((w_byte == 8'h0A) || (w_byte == 8'h0B)) begin
              w_nextState = S_ADDR;
            end else begin
              w_nextState = S_IGNORE;
            end
          end
        end
        S_ADDR:  if (w_byteDone) w_nextState = r_isRead ? S_READ : S_WRITE;
        default: ;
      endcase
    end
  end

  // Per-state control strobes for the pointer, storage and MISO shifter.
  always_comb begin
    w_cmdDone  = 1'b0;
    w_ptrLoad  = 1'b0;
    w_ptrInc   = 1'b0;
    w_wrEn     = 1'b0;
    w_outLoad  = 1'b0;
    w_outShift = 1'b0;
    if (!w_csHigh) begin
      case (r_state)
        S_CMD:  w_cmdDone = w_byteDone;
        S_ADDR: w_ptrLoad = w_byteDone;
        S_WRITE: begin
          w_ptrInc = w_byteDone;
          w_wrEn   = w_byteDone && w_writable;
        end
        S_READ: begin
          if (w_sclkFall) begin
            if (r_bitCnt == 3'd0) begin
              w_outLoad = 1'b1;
              w_ptrInc  = 1'b1;
            end else begin
              w_outShift = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Assemble MOSI bytes on SCLK rising edges; any idle period drops a partial byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitCnt  <= 3'd0;
      r_shiftIn <= 7'd0;
    end else if (w_csHigh || (r_state == S_IDLE)) begin
      r_bitCnt  <= 3'd0;
      r_shiftIn <= 7'd0;
    end else if (w_sclkRise) begin
      r_bitCnt  <= r_bitCnt + 3'd1;
      r_shiftIn <= w_byte[6:0];
    end
  end

  // Command latch, address pointer and the MISO output shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_isRead   <= 1'b0;
      r_ptr      <= '0;
      r_shiftOut <= 7'd0;
      r_miso     <= 1'b0;
    end else begin
      if (w_cmdDone) r_isRead <= (w_byte == 8'h0B);
      if (w_ptrLoad) begin
        r_ptr <= w_byte[ADDR_W-1:0];
      end else if (w_ptrInc) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end
      if (w_outLoad) begin
        r_shiftOut <= w_rdData[6:0];
      end else if (w_outShift) begin
        r_shiftOut <= {r_shiftOut[5:0], 1'b0};
      end
      if (w_nextState != S_READ) begin
        r_miso <= 1'b0;
      end else if (w_outLoad) begin
        r_miso <= w_rdData[7];
      end else if (w_outShift) begin
        r_miso <= r_shiftOut[6];
      end
    end
  end

  assign MISO = r_miso;

  // Writable storage, including POWER_CTL; read-only locations never change here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_wrEn) begin
      r_mem[r_ptr] <= w_byte;
    end
  end

  // Sample generator: advances X/Y/Z once per prescaler wrap in measure mode only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_x     <= 16'd0;
      r_y     <= 16'd0;
      r_z     <= 16'd0;
    end else if (w_measure) begin
      if (r_presc == L_PRESC_LAST) begin
        r_presc <= '0;
        r_x     <= r_x + 16'd1;
        r_y     <= r_y + 16'd2;
        r_z     <= r_z - 16'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Freeze the samples at CS fall so a burst read sees one consistent set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snapX <= 16'd0;
      r_snapY <= 16'd0;
      r_snapZ <= 16'd0;
    end else if ((r_state == S_IDLE) && w_csFall) begin
      r_snapX <= r_x;
      r_snapY <= r_y;
      r_snapZ <= r_z;
    end
  end

endmodule
